// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - writeback trap sequencer: trap record, flush and PC redirect (option: TRAP_CTRL_IRQ_EN)
// wb_trap_o layout: {valid, pc[31:0], is_interrupt, mcause[30:0]}.
module trap_ctrl #(
    parameter int unsigned REDIRECT_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_valid_i,
    input  logic [31:0] wb_pc_i,
    input  logic        wb_exc_valid_i,
    input  logic [4:0]  wb_exc_cause_i,
    input  logic        wb_mret_i,
    input  logic [31:0] trap_handler_addr_i,
    input  logic [31:0] mepc_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        fetch_ready_i,
    output logic        wb_valid_insn_o,
    output logic [64:0] wb_trap_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        hang_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(REDIRECT_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hang_q, hang_d;
    logic [31:0] target_q, target_d;

    logic        irq_req;
    logic        irq_ext_sel;
    logic        event_taken;
    logic        trap_valid;
    logic        trap_irq;
    logic [30:0] trap_cause;
    logic        flush;
    logic        redir;
    logic        valid_insn;

`ifdef TRAP_CTRL_IRQ_EN
    assign irq_req     = irq_ext_i | irq_timer_i;
    assign irq_ext_sel = irq_ext_i;
`else
    logic unused_irq;
    assign unused_irq  = irq_ext_i ^ irq_timer_i;
    assign irq_req     = 1'b0;
    assign irq_ext_sel = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            hang_q   <= 1'b0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hang_q   <= hang_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hang_d      = hang_q;
        target_d    = target_q;
        event_taken = 1'b0;
        trap_valid  = 1'b0;
        trap_irq    = 1'b0;
        trap_cause  = 31'd0;
        flush       = 1'b0;
        redir       = 1'b0;
        valid_insn  = 1'b0;

        case (state_q)
            IDLE: begin
                valid_insn = wb_valid_i;
                if (wb_valid_i) begin
                    if (wb_exc_valid_i) begin
                        event_taken = 1'b1;
                        trap_valid  = 1'b1;
                        trap_cause  = {26'd0, wb_exc_cause_i};
                        target_d    = {trap_handler_addr_i[31:2], 2'b00};
                    end else if (irq_req) begin
                        // Interrupted instruction is not executed; mepc points back at it.
                        event_taken = 1'b1;
                        trap_valid  = 1'b1;
                        trap_irq    = 1'b1;
                        trap_cause  = irq_ext_sel ? 31'd11 : 31'd7;
                        target_d    = {trap_handler_addr_i[31:2], 2'b00};
                    end else if (wb_mret_i) begin
                        event_taken = 1'b1;
                        target_d    = mepc_i;
                    end
                end
                if (event_taken) begin
                    flush   = 1'b1;
                    state_d = REDIRECT;
                    cnt_d   = 8'd0;
                end
            end
            REDIRECT: begin
                flush = 1'b1;
                redir = 1'b1;
                if (fetch_ready_i) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    // Hang is only a diagnostic; the FSM keeps waiting for fetch.
                    if (cnt_d >= TIMEOUT) begin
                        hang_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is asserted.
    assign wb_valid_insn_o  = rst_ni & valid_insn;
    assign flush_o          = rst_ni & flush;
    assign redirect_valid_o = rst_ni & redir;
    assign redirect_pc_o    = (rst_ni & redir) ? target_q : 32'd0;
    assign hang_o           = hang_q;
    assign wb_trap_o        = (rst_ni & trap_valid)
                              ? {1'b1, wb_pc_i, trap_irq, trap_cause}
                              : 65'd0;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Writeback-side trap sequencer, directly upstream of the CSR file.
- Converts WB-stage exceptions, `mret` and (optionally) interrupts into the trap record the CSR file latches into mepc/mcause.
- Flushes the pipeline and drives a PC redirect handshake to fetch: target is the CSR file's handler address, or mepc for `mret`.
- Owns the only FSM that decides when architectural control flow leaves the sequential path.

Parameters:
- REDIRECT_TIMEOUT, 16: cycles REDIRECT may wait for fetch acceptance before the sticky hang flag sets; legal range 1..255.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- wb_valid_i  in  1  WB stage holds a valid instruction this cycle
- wb_pc_i  in  32  PC of WB instruction
- wb_exc_valid_i  in  1  WB instruction raised a synchronous exception
- wb_exc_cause_i  in  5  exception code (RISC-V mcause encoding)
- wb_mret_i  in  1  WB instruction is `mret`
- trap_handler_addr_i  in  32  handler base from CSR file (mtvec, word-aligned)
- mepc_i  in  32  current mepc from CSR file
- irq_ext_i  in  1  machine external interrupt request, level
- irq_timer_i  in  1  machine timer interrupt request, level
- fetch_ready_i  in  1  fetch accepts redirect
- wb_valid_insn_o  out  1  to CSR file WB_valid_insn_i
- wb_trap_o  out  trap_info_t  to CSR file WB_trap_i: valid, pc, is_interrupt, mcause[30:0]
- flush_o  out  1  kill all younger pipeline contents
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  32  redirect target
- hang_o  out  1  sticky: redirect timed out

Behaviour:
- Reset (async assert, sync deassert on clk_i): state = IDLE, timeout counter = 0, hang_o = 0, latched target = 0.
  - All outputs 0 during reset.
- States: IDLE and REDIRECT.
- IDLE, event selection when wb_valid_i = 1, priority exception > interrupt > mret:
  - Exception: wb_trap_o.valid = 1, pc = wb_pc_i, is_interrupt = 0, mcause = zero-extended wb_exc_cause_i. Latched target = {trap_handler_addr_i[31:2], 2'b00}.
  - Interrupt (feature only): wb_trap_o.valid = 1, pc = wb_pc_i (instruction not executed, resumes there), is_interrupt = 1, mcause = 11 if irq_ext_i, else 7 for timer. Latched target as for exception.
  - mret: wb_trap_o.valid = 0; latched target = mepc_i.
  - Any of the three: flush_o = 1 combinationally in the same cycle, next state = REDIRECT, counter cleared.
  - Otherwise: wb_trap_o.valid = 0, flush_o = 0, stay in IDLE.
- wb_valid_insn_o = wb_valid_i in IDLE (including the trapping instruction, so the CSR file latches the trap), 0 in REDIRECT.
- wb_trap_o fields are combinational from the current inputs and are valid in the event cycle only.
- REDIRECT:
  - flush_o = 1, redirect_valid_o = 1, redirect_pc_o = latched target (stable for the whole state).
  - All WB inputs and interrupts are ignored.
  - fetch_ready_i = 1: redirect completes this cycle, next state = IDLE.
  - Otherwise counter increments, saturating at 255. When counter reaches REDIRECT_TIMEOUT, hang_o = 1 and stays 1 until reset; the FSM keeps waiting.
- redirect_valid_o must not drop before acceptance; redirect_pc_o must not change while redirect_valid_o = 1.
- Back-to-back: an event in the first IDLE cycle after a redirect is legal, so minimum trap-to-trap spacing is 2 cycles.
- Reset mid-REDIRECT: aborts immediately; no redirect is issued after release.

Optional Feature:
- Macro TRAP_CTRL_IRQ_EN.
- Defined: irq_ext_i and irq_timer_i are sampled in IDLE alongside a valid WB instruction, as described above.
- Undefined: the IRQ ports remain on the interface but are ignored; is_interrupt is always 0.

Test Plan:
- Illegal instruction: wb_valid_i = 1, wb_exc_valid_i = 1, cause = 2, pc = 0x100, mtvec = 0x400 -> same cycle: trap valid, mcause = 2, is_interrupt = 0, flush_o = 1. Next cycle: redirect_valid_o = 1, redirect_pc_o = 0x400. fetch_ready_i held 1 -> IDLE next cycle.
- mret with mepc_i = 0x104 -> no trap valid; redirect_pc_o = 0x104.
- Priority: exception + mret + irq_ext_i together, feature on -> exception taken, mcause = 2, is_interrupt = 0.
- Interrupt, feature on: irq_timer_i with WB pc = 0x200 -> trap pc = 0x200, is_interrupt = 1, mcause = 7. Feature off -> no event.
- Timeout: REDIRECT_TIMEOUT = 4, fetch_ready_i held 0 -> hang_o rises on the 4th REDIRECT wait cycle and stays high after a later fetch_ready_i.
- Reset: rst_ni pulsed low mid-REDIRECT, asynchronous to clk_i -> outputs go 0 immediately; hang_o = 0; no redirect after release.
